blake2s_block_sched: RTL

Block scheduler for the BLAKE2s datapath. It sits between a byte-stream source (the IO interface or an on-chip requester) and the `blake2s_hash256` core. It turns a message of `ll` bytes (plus an optional key) into a sequence of 64-byte blocks with zero padding. It drives `data_v`/`data_idx`/`block_first`/`block_last` toward the core, waits for core readiness between blocks, then collects `nn` digest bytes and signals completion.

---
 rtl/blake2s_pkg.sv | 17 +
 rtl/blake2s_block_sched_if.sv | 40 ++++
 rtl/blake2s_digest_cnt.sv | 44 ++++
 rtl/blake2s_block_sched.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/blake2s_pkg.sv
// Shared definitions for the BLAKE2s block scheduler.
//   sched_state_t       : scheduler state encoding
//   BLAKE2S_BLOCK_BYTES : bytes per compression block
//   BLAKE2S_MAX_NN      : largest digest (and key) length in bytes
package blake2s_pkg;

    localparam int BLAKE2S_BLOCK_BYTES = 64;
    localparam int BLAKE2S_MAX_NN      = 32;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_WAIT_RDY,
        SCHED_FEED,
        SCHED_HASH
    } sched_state_t;

endpackage

// File: rtl/blake2s_block_sched_if.sv
// Handshake/bus bundle between the block scheduler, its byte source,
// the blake2s_hash256 core and the digest consumer.
//   slave  : the scheduler side (takes start/config/source/core inputs)
//   master : the environment side (drives those inputs, observes outputs)
interface blake2s_block_sched_if;
    logic        start_i;
    logic [5:0]  kk_i;
    logic [5:0]  nn_i;
    logic [63:0] ll_i;
    logic        in_v_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        core_ready_i;
    logic [5:0]  kk_o;
    logic [5:0]  nn_o;
    logic [63:0] ll_o;
    logic        data_v_o;
    logic [7:0]  data_o;
    logic [5:0]  data_idx_o;
    logic        block_first_o;
    logic        block_last_o;
    logic        h_v_i;
    logic [7:0]  h_i;
    logic        hash_v_o;
    logic [7:0]  hash_o;
    logic        busy_o;
    logic        done_o;

    modport slave (
        input  start_i, kk_i, nn_i, ll_i, in_v_i, in_data_i, core_ready_i, h_v_i, h_i,
        output in_ready_o, kk_o, nn_o, ll_o, data_v_o, data_o, data_idx_o,
               block_first_o, block_last_o, hash_v_o, hash_o, busy_o, done_o
    );

    modport master (
        output start_i, kk_i, nn_i, ll_i, in_v_i, in_data_i, core_ready_i, h_v_i, h_i,
        input  in_ready_o, kk_o, nn_o, ll_o, data_v_o, data_o, data_idx_o,
               block_first_o, block_last_o, hash_v_o, hash_o, busy_o, done_o
    );
endinterface

// File: rtl/blake2s_digest_cnt.sv
// HASH-phase digest forwarder: registers each core digest byte onto
// hash/hash_v, counts them, and pulses done with the nn-th byte.
//   en        : scheduler is in HASH
//   nn        : digest length (already clamped to 1..32)
//   h_v, h    : core digest byte
//   hash_v    : registered digest valid, hash : registered digest byte
//   done      : registered, coincides with the last hash_v
//   last_byte : combinational, the nn-th byte is being taken this cycle
module blake2s_digest_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [5:0] nn,
    input  logic       h_v,
    input  logic [7:0] h,
    output logic       hash_v,
    output logic [7:0] hash,
    output logic       done,
    output logic       last_byte
);
    logic [5:0] cnt;
    logic       take;

    assign take      = en && h_v;
    assign last_byte = take && (cnt == nn - 6'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            hash_v <= 1'b0;
            hash   <= '0;
            done   <= 1'b0;
        end else begin
            hash_v <= take;
            done   <= last_byte;
            if (take)
                hash <= h;
            if (!en || last_byte)
                cnt <= '0;
            else if (h_v)
                cnt <= cnt + 6'd1;
        end
    end
endmodule

// File: rtl/blake2s_block_sched.sv
// BLAKE2s block scheduler: slices key + message bytes into 64-byte
// zero-padded blocks for the hash core, then forwards nn digest bytes.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : blake2s_block_sched_if.slave (start/config, byte source,
//                core block stream, digest in/out, busy/done)
// Optional feature macro: BLAKE2S_SCHED_KEY_EN (keyed hashing; when
// undefined the key length is forced to 0 and kk_i is ignored).
module blake2s_block_sched
    import blake2s_pkg::*;
#(
    parameter int BLOCK_BYTES = BLAKE2S_BLOCK_BYTES,
    parameter int MAX_NN      = BLAKE2S_MAX_NN
) (
    input  logic                  clk,
    input  logic                  reset,
    blake2s_block_sched_if.slave  bus
);
    sched_state_t state, state_nx;

    logic [5:0]  nn_r;
    logic [63:0] ll_r;
    logic [63:0] rem;
    logic        first;
    logic        last;
    logic [5:0]  idx;
    logic [5:0]  nn_eff;
    logic        slot_real;
    logic        beat;
    logic        blk_end;
    logic        in_ready;
    logic [7:0]  data;
    logic        digest_last;
    logic        key_blk;
    logic        krem_nz;

    assign nn_eff = (bus.nn_i == 6'd0 || bus.nn_i > 6'(MAX_NN)) ? 6'(MAX_NN) : bus.nn_i;

`ifdef BLAKE2S_SCHED_KEY_EN
    logic [5:0] kk_r;
    logic [5:0] krem;
    logic [5:0] kk_eff;

    assign kk_eff   = (bus.kk_i > 6'(MAX_NN)) ? 6'(MAX_NN) : bus.kk_i;
    assign krem_nz  = (krem != 6'd0);
    assign bus.kk_o = kk_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kk_r    <= '0;
            krem    <= '0;
            key_blk <= 1'b0;
        end else if (state == SCHED_IDLE && bus.start_i) begin
            kk_r    <= kk_eff;
            krem    <= kk_eff;
            key_blk <= (kk_eff != 6'd0);
        end else if (beat) begin
            if (slot_real && key_blk)
                krem <= krem - 6'd1;
            if (blk_end && !last)
                key_blk <= 1'b0;
        end
    end
`else
    assign key_blk  = 1'b0;
    assign krem_nz  = 1'b0;
    assign bus.kk_o = 6'd0;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        beat      = 1'b0;
        data      = 8'h00;
        slot_real = key_blk ? krem_nz : (rem != 64'd0);
        case (state)
            SCHED_IDLE:
                if (bus.start_i)
                    state_nx = SCHED_WAIT_RDY;
            SCHED_WAIT_RDY:
                if (bus.core_ready_i)
                    state_nx = SCHED_FEED;
            SCHED_FEED: begin
                // Real slots stall on the source; pad slots always advance.
                in_ready = slot_real;
                beat     = slot_real ? bus.in_v_i : 1'b1;
                data     = slot_real ? bus.in_data_i : 8'h00;
                if (beat && idx == 6'(BLOCK_BYTES - 1))
                    state_nx = last ? SCHED_HASH : SCHED_WAIT_RDY;
            end
            SCHED_HASH:
                if (digest_last)
                    state_nx = SCHED_IDLE;
            default:
                state_nx = SCHED_IDLE;
        endcase
    end

    assign blk_end = beat && (idx == 6'(BLOCK_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SCHED_IDLE;
            nn_r  <= '0;
            ll_r  <= '0;
            rem   <= '0;
            first <= 1'b0;
            last  <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (state == SCHED_IDLE && bus.start_i) begin
                nn_r  <= nn_eff;
                ll_r  <= bus.ll_i;
                rem   <= bus.ll_i;
                first <= 1'b1;
            end else if (state == SCHED_WAIT_RDY && bus.core_ready_i) begin
                idx  <= '0;
                // A key block is final only for an empty message.
                last <= key_blk ? (ll_r == 64'd0) : (rem <= 64'(BLOCK_BYTES));
            end else if (beat) begin
                idx <= idx + 6'd1;
                if (slot_real && !key_blk)
                    rem <= rem - 64'd1;
                if (blk_end && !last)
                    first <= 1'b0;
            end
        end
    end

    blake2s_digest_cnt u_digest_cnt (
        .clk       (clk),
        .reset     (reset),
        .en        (state == SCHED_HASH),
        .nn        (nn_r),
        .h_v       (bus.h_v_i),
        .h         (bus.h_i),
        .hash_v    (bus.hash_v_o),
        .hash      (bus.hash_o),
        .done      (bus.done_o),
        .last_byte (digest_last)
    );

    assign bus.in_ready_o    = in_ready;
    assign bus.data_v_o      = beat;
    assign bus.data_o        = data;
    assign bus.data_idx_o    = (state == SCHED_FEED) ? idx : 6'd0;
    assign bus.block_first_o = (state == SCHED_FEED) && first;
    assign bus.block_last_o  = (state == SCHED_FEED) && last;
    assign bus.nn_o          = nn_r;
    assign bus.ll_o          = ll_r;
    assign bus.busy_o        = (state != SCHED_IDLE);
endmodule
